// File: rtl/wb_apb_bridge_multi.sv
// rtl/wb_apb_bridge_multi.sv - Wishbone slave to multi-slave APB3 bridge with timeout and sticky error.
module wb_apb_bridge_multi #(
    parameter int          NSLV      = 4,
    parameter int          WIN_BITS  = 12,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [WIN_BITS-1:0]   paddr_o,
    output logic [NSLV-1:0]       psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [31:0]           pwdata_o,
    output logic [3:0]            pstrb_o,
    input  logic [NSLV*32-1:0]    prdata_i,
    input  logic [NSLV-1:0]       pready_i,
    input  logic [NSLV-1:0]       pslverr_i,
    input  logic                  err_clr_i,
    output logic                  err_irq_o,
    output logic [1:0]            err_code_o
);
    localparam int IDX_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int DEC_LO = WIN_BITS + IDX_W;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W:0]    NSLV_LIM = (IDX_W + 1)'(NSLV);
    localparam logic [TO_W-1:0]   TO_LIM   = TO_W'(TIMEOUT);
    localparam logic [NSLV-1:0]   SEL_ONE  = NSLV'(1);
    localparam logic [31:0]       ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_r;
    logic [TO_W-1:0]  timeout_cnt;

    logic [IDX_W-1:0] dec_idx;
    logic             dec_hit;
    logic             sel_ready;
    logic             sel_err;
    logic [31:0]      sel_rdata;
    logic [TO_W-1:0]  cnt_next;
    logic             timed_out;
    logic             err_event;
    logic [1:0]       err_event_code;

    assign dec_idx   = wbs_adr_i[DEC_LO-1:WIN_BITS];
    assign dec_hit   = (wbs_adr_i[31:DEC_LO] == BASE_ADDR[31:DEC_LO]) &&
                       ({1'b0, dec_idx} < NSLV_LIM);
    assign sel_ready = pready_i[idx_r];
    assign sel_err   = pslverr_i[idx_r];
    assign sel_rdata = prdata_i[{idx_r, 5'b00000} +: 32];
    assign cnt_next  = timeout_cnt + TO_W'(1);
    assign timed_out = (TIMEOUT != 0) && (cnt_next == TO_LIM);

    always_comb begin
        err_event      = 1'b0;
        err_event_code = 2'b00;
        case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i && !dec_hit) begin
                    err_event      = 1'b1;
                    err_event_code = 2'b01;
                end
            end
            ACCESS: begin
                if (sel_ready && sel_err) begin
                    err_event      = 1'b1;
                    err_event_code = 2'b10;
                end else if (!sel_ready && timed_out) begin
                    err_event      = 1'b1;
                    err_event_code = 2'b11;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            idx_r       <= '0;
            timeout_cnt <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            paddr_o     <= '0;
            psel_o      <= '0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
            err_irq_o   <= 1'b0;
            err_code_o  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        if (dec_hit) begin
                            idx_r    <= dec_idx;
                            psel_o   <= SEL_ONE << dec_idx;
                            paddr_o  <= wbs_adr_i[WIN_BITS-1:0];
                            pwrite_o <= wbs_we_i;
                            pwdata_o <= wbs_dat_i;
                            pstrb_o  <= wbs_we_i ? wbs_sel_i : 4'b0000;
                            state    <= SETUP;
                        end else begin
                            wbs_dat_o <= ERR_DATA;
                            wbs_ack_o <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_o   <= 1'b1;
                    timeout_cnt <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // APB cannot abort, so a dropped cyc only suppresses the ack.
                    if (sel_ready || timed_out) begin
                        if (sel_ready && !sel_err)
                            wbs_dat_o <= pwrite_o ? 32'h0 : sel_rdata;
                        else
                            wbs_dat_o <= ERR_DATA;
                        psel_o    <= '0;
                        penable_o <= 1'b0;
                        wbs_ack_o <= wbs_cyc_i;
                        state     <= RESP;
                    end
                    if (!sel_ready)
                        timeout_cnt <= cnt_next;
                end
                RESP: begin
                    wbs_ack_o <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A new error outranks a clear in the same cycle.
            if (err_event) begin
                err_irq_o  <= 1'b1;
                err_code_o <= err_event_code;
            end else if (err_clr_i) begin
                err_irq_o <= 1'b0;
            end
        end
    end
endmodule
